huffman_dec_ctrl: RTL and testbench

//  Stream controller for the serial Huffman decoder (18-symbol, max 8-bit prefix code).

---
 rtl/huffman_dec_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_huffman_dec_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : huffman_dec_ctrl
// Purpose  : Stream controller for a serial Huffman decoder. Serialises packed
//            code bytes MSB-first into the decoder, collects decoded symbols
//            in a small output FIFO, counts symbols per frame and aborts a
//            frame whose current code grows past MAX_CODE_LEN bits.
// Options  : HUFF_CTRL_STATS_EN adds per-frame statistics outputs
//            stat_bits (bits sent, saturating) and stat_maxlen (longest code).
// Revision : 1.0 - initial release
// ============================================================================
module huffman_dec_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_CODE_LEN = 8,
  parameter int SYM_W        = 6,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,            // asynchronous, active-low
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             dec_clr,
  output logic             dec_bit,
  output logic             dec_bit_en,
  input  logic [SYM_W-1:0] dec_sym,
  input  logic             dec_sym_valid,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef HUFF_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_bits,
  output logic [3:0]       stat_maxlen
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W:0] c_depth    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [3:0]     c_len_last = 4'(MAX_CODE_LEN - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_clr   = 3'd1;
  localparam logic [2:0] c_st_load  = 3'd2;
  localparam logic [2:0] c_st_shift = 3'd3;
  localparam logic [2:0] c_st_drain = 3'd4;
  localparam logic [2:0] c_st_done  = 3'd5;
  localparam logic [2:0] c_st_err   = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_frame_len;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] w_sym_cnt_nxt;
  logic [3:0]       r_code_len;
  logic [7:0]       r_shreg;
  logic [2:0]       r_bit_idx;
  logic             r_err;

  logic [SYM_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_bit_en;
  logic w_push;
  logic w_pop;
  logic w_flush;
  logic w_frame_end;
  logic w_accept_start;

  // Handshake and control qualifiers; full is taken from the registered count
  // so a pop only frees a slot for the shifter on the following cycle.
  always_comb begin
    w_full         = (r_count == c_depth);
    w_bit_en       = (r_state == c_st_shift) && !w_full;
    w_push         = w_bit_en && dec_sym_valid;
    w_pop          = (r_count != '0) && sym_ready;
    w_flush        = (r_state == c_st_err);
    w_sym_cnt_nxt  = r_sym_cnt + CNT_W'(1);
    w_frame_end    = (w_sym_cnt_nxt == r_frame_len);
    w_accept_start = (r_state == c_st_idle) && start;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; frame end beats byte reload, code overrun beats reload
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_clr;
      c_st_clr:   w_state_nxt = (r_frame_len == '0) ? c_st_done : c_st_load;
      c_st_load:  if (byte_valid) w_state_nxt = c_st_shift;
      c_st_shift: begin
        if (w_bit_en) begin
          if (w_push) begin
            if (w_frame_end)            w_state_nxt = c_st_drain;
            else if (r_bit_idx == 3'd0) w_state_nxt = c_st_load;
          end else begin
            if (r_code_len == c_len_last) w_state_nxt = c_st_err;
            else if (r_bit_idx == 3'd0)   w_state_nxt = c_st_load;
          end
        end
      end
      c_st_drain: if (r_count == '0) w_state_nxt = c_st_done;
      c_st_done:  w_state_nxt = c_st_idle;
      c_st_err:   w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Moore-style outputs decoded from the current state
  always_comb begin
    byte_ready = (r_state == c_st_load);
    dec_clr    = (r_state == c_st_clr) || (r_state == c_st_err);
    dec_bit    = (r_state == c_st_shift) ? r_shreg[7] : 1'b0;
    dec_bit_en = w_bit_en;
    busy       = (r_state != c_st_idle);
    done       = (r_state == c_st_done);
    err        = r_err;
    sym_valid  = (r_count != '0);
    sym_out    = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  end

  // Frame bookkeeping: shift register, bit index, code length, symbol count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_len <= '0;
      r_sym_cnt   <= '0;
      r_code_len  <= '0;
      r_shreg     <= '0;
      r_bit_idx   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept_start) begin
        r_frame_len <= frame_len;
        r_sym_cnt   <= '0;
        r_code_len  <= '0;
        r_err       <= 1'b0;
      end
      if ((r_state == c_st_load) && byte_valid) begin
        r_shreg   <= byte_in;
        r_bit_idx <= 3'd7;
      end
      if (w_bit_en) begin
        r_shreg   <= {r_shreg[6:0], 1'b0};
        r_bit_idx <= r_bit_idx - 3'd1;
        if (w_push) begin
          r_code_len <= '0;
          r_sym_cnt  <= w_sym_cnt_nxt;
        end else begin
          r_code_len <= r_code_len + 4'd1;
        end
      end
      if (w_flush) r_err <= 1'b1;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= dec_sym;
  end

  // FIFO pointers and occupancy; an aborted frame empties the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef HUFF_CTRL_STATS_EN
  logic [CNT_W-1:0] r_stat_bits;
  logic [3:0]       r_stat_maxlen;
  logic [3:0]       w_len_now;

  // Length of the code completed by the current bit
  always_comb begin
    w_len_now = r_code_len + 4'd1;
  end

  // Per-frame statistics, cleared on an accepted start and held afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_bits   <= '0;
      r_stat_maxlen <= '0;
    end else if (w_accept_start) begin
      r_stat_bits   <= '0;
      r_stat_maxlen <= '0;
    end else begin
      if (w_bit_en && (r_stat_bits != '1)) r_stat_bits <= r_stat_bits + CNT_W'(1);
      if (w_push && (w_len_now > r_stat_maxlen)) r_stat_maxlen <= w_len_now;
    end
  end

  assign stat_bits   = r_stat_bits;
  assign stat_maxlen = r_stat_maxlen;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_huffman_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_huffman_dec_ctrl
// Purpose  : Self-checking bench for huffman_dec_ctrl with a behavioural
//            18-symbol decoder model, byte feeder and symbol scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_huffman_dec_ctrl;

  localparam int SYM_W = 6;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] frame_len = '0;
  logic [7:0]       byte_in = '0;
  logic             byte_valid = 1'b0;
  logic             byte_ready;
  logic             dec_clr;
  logic             dec_bit;
  logic             dec_bit_en;
  logic [SYM_W-1:0] dec_sym;
  logic             dec_sym_valid;
  logic [SYM_W-1:0] sym_out;
  logic             sym_valid;
  logic             sym_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  huffman_dec_ctrl #(
    .FIFO_DEPTH(4), .MAX_CODE_LEN(8), .SYM_W(SYM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .dec_clr(dec_clr), .dec_bit(dec_bit), .dec_bit_en(dec_bit_en),
    .dec_sym(dec_sym), .dec_sym_valid(dec_sym_valid),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q [$];
  logic [7:0] byte_q [$];
  int cyc = 0, n_push = 0, n_bits = 0, n_done = 0, n_rdy = 0, n_clr = 0, n_bytes = 0;
  int last_pop_cyc = 0, done_cyc = 0;
  logic never_valid = 1'b0;
  logic feed_hs;
  logic [5:0] mon_exp;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Code table: 1=00 2=010 3=011 4=110 5=100 6=101 7..10=1110xx
  // 11..14=11110xx 15,16=111110x 17=11111110 18=11111111
  function automatic logic [5:0] lookup(input logic [3:0] len, input logic [7:0] v);
    logic [5:0] s;
    s = '0;
    case (len)
      4'd2: if (v[1:0] == 2'b00) s = 6'd1;
      4'd3: case (v[2:0])
              3'b010:  s = 6'd2;
              3'b011:  s = 6'd3;
              3'b110:  s = 6'd4;
              3'b100:  s = 6'd5;
              3'b101:  s = 6'd6;
              default: s = 6'd0;
            endcase
      4'd6: if (v[5:2] == 4'b1110) s = 6'd7 + {4'd0, v[1:0]};
      4'd7: begin
        if (v[6:2] == 5'b11110)       s = 6'd11 + {4'd0, v[1:0]};
        else if (v[6:1] == 6'b111110) s = 6'd15 + {5'd0, v[0]};
      end
      4'd8: if (v[7:1] == 7'b1111111) s = 6'd17 + {5'd0, v[0]};
      default: s = 6'd0;
    endcase
    return s;
  endfunction

  logic [7:0] m_bits;
  logic [3:0] m_len;
  logic [5:0] m_hit;

  always_comb m_hit = lookup(m_len + 4'd1, {m_bits[6:0], dec_bit});
  assign dec_sym       = m_hit;
  assign dec_sym_valid = dec_bit_en && !never_valid && (m_hit != 6'd0);

  // Decoder model bit accumulator
  always @(posedge clk or negedge rst) begin
    if (!rst || dec_clr) begin
      m_bits <= '0;
      m_len  <= '0;
    end else if (dec_bit_en) begin
      if (dec_sym_valid) begin
        m_bits <= '0;
        m_len  <= '0;
      end else begin
        m_bits <= {m_bits[6:0], dec_bit};
        m_len  <= m_len + 4'd1;
      end
    end
  end

  // Byte feeder
  initial begin
    forever begin
      @(negedge clk);
      feed_hs = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      if (feed_hs && byte_q.size() > 0) begin
        void'(byte_q.pop_front());
        n_bytes++;
      end
      byte_valid = (byte_q.size() > 0);
      byte_in    = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
    end
  end

  // Monitor and scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (dec_bit_en) n_bits++;
        if (dec_bit_en && dec_sym_valid) n_push++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (byte_ready) n_rdy++;
        if (dec_clr) n_clr++;
        if (sym_valid && sym_ready) begin
          last_pop_cyc = cyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_sym actual=%0d expected=none", sym_out);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("sym_out", int'(sym_out), int'(mon_exp));
          end
        end
      end
    end
  end

  task automatic begin_frame(input int len);
    @(posedge clk);
    #1;
    n_push = 0; n_bits = 0; n_done = 0; n_rdy = 0; n_clr = 0; n_bytes = 0;
    frame_len = CNT_W'(len);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=busy expected=idle", nm);
    end
    @(negedge clk);
  endtask

  task automatic frame_zeros4(input string nm);
    sym_ready = 1'b1;
    byte_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back(6'd1);
    begin_frame(4);
    wait_idle(nm);
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_done"}, n_done, 1);
    chk({nm, "_done_lat"}, done_cyc - last_pop_cyc, 2);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_bytes"}, n_bytes, 1);
  endtask

  initial begin
    int k;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_byte_ready", int'(byte_ready), 0);
    chk("rst_dec_clr", int'(dec_clr), 0);
    chk("rst_dec_bit", int'(dec_bit), 0);
    chk("rst_dec_bit_en", int'(dec_bit_en), 0);
    chk("rst_sym_valid", int'(sym_valid), 0);
    chk("rst_sym_out", int'(sym_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // four 2-bit codes filling exactly one byte
    frame_zeros4("A");

    // 110 00 then frame end: rest of byte dropped, second byte untouched
    byte_q.push_back(8'hC0);
    byte_q.push_back(8'h00);
    exp_q.push_back(6'd4);
    exp_q.push_back(6'd1);
    begin_frame(2);
    wait_idle("B");
    chk("B_left", exp_q.size(), 0);
    chk("B_bytes", n_bytes, 1);
    chk("B_bits", n_bits, 5);
    byte_q.delete();

    // longest (8-bit) code is legal
    byte_q.push_back(8'hFF);
    exp_q.push_back(6'd18);
    begin_frame(1);
    wait_idle("C");
    chk("C_left", exp_q.size(), 0);
    chk("C_bits", n_bits, 8);
    chk("C_err", int'(err), 0);
    chk("C_done", n_done, 1);

    // backpressure: FIFO fills, shifter stalls, no symbol lost
    sym_ready = 1'b0;
    byte_q.push_back(8'h00);
    byte_q.push_back(8'h00);
    for (int i = 0; i < 6; i++) exp_q.push_back(6'd1);
    begin_frame(6);
    repeat (30) @(negedge clk);
    chk("D_stall_push", n_push, 4);
    chk("D_stall_en", int'(dec_bit_en), 0);
    chk("D_stall_busy", int'(busy), 1);
    chk("D_stall_bytes", n_bytes, 2);
    @(posedge clk);
    #1;
    sym_ready = 1'b1;
    wait_idle("D");
    chk("D_left", exp_q.size(), 0);
    chk("D_push", n_push, 6);
    chk("D_done", n_done, 1);

    // no code ever completes: abort after 8 bits
    never_valid = 1'b1;
    byte_q.push_back(8'h00);
    byte_q.push_back(8'h00);
    begin_frame(3);
    wait_idle("E");
    chk("E_err", int'(err), 1);
    chk("E_busy", int'(busy), 0);
    chk("E_done", n_done, 0);
    chk("E_bits", n_bits, 8);
    chk("E_sym_valid", int'(sym_valid), 0);
    chk("E_clr", n_clr, 2);
    never_valid = 1'b0;
    byte_q.delete();

    // empty frame: done without any byte request, err cleared by start
    begin_frame(0);
    wait_idle("F");
    chk("F_done", n_done, 1);
    chk("F_rdy", n_rdy, 0);
    chk("F_err", int'(err), 0);
    chk("F_clr", n_clr, 1);

    // asynchronous reset in the middle of shifting
    sym_ready = 1'b0;
    byte_q.push_back(8'h00);
    begin_frame(4);
    k = 0;
    while (!dec_bit_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("G_reached_shift", int'(dec_bit_en), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("G_busy", int'(busy), 0);
    chk("G_dec_bit_en", int'(dec_bit_en), 0);
    chk("G_byte_ready", int'(byte_ready), 0);
    chk("G_sym_valid", int'(sym_valid), 0);
    chk("G_dec_clr", int'(dec_clr), 0);
    chk("G_done", int'(done), 0);
    @(negedge clk);
    byte_q.delete();
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // normal operation after reset
    frame_zeros4("H");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
